uart_tx_frame: RTL and testbench

UART transmitter, the transmit-side counterpart of the UART receiver. Accepts one parallel byte per valid strobe and serialises it as start bit, 8 data bits LSB first, an optional parity bit and one stop bit. Each bit lasts prescale clock cycles, so it uses the same clock and prescale value as the receiver. Sits between the system/register-file data path and the serial TX pin.

---
 rtl/uart_tx_frame.sv | 146 ++++++++++++++
 tb/tb_uart_tx_frame.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_frame.sv
// UART transmitter: serialises one latched byte as start, 8 data bits LSB first,
// optional parity and one stop bit, each bit lasting prescale clock cycles.
module uart_tx_frame #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_WIDTH-1:0]     p_data,
    input  logic                      data_valid,
    input  logic                      par_en,
    input  logic                      par_typ,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    output logic                      tx_out,
    output logic                      busy
);

    localparam int IDX_W = $clog2(DATA_WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // Parity over the data byte; odd=1 flips it so data plus parity has an odd count of ones.
    function automatic logic parity_bit(input logic [DATA_WIDTH-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

    state_t                    state_r;
    logic [PRESCALE_WIDTH-1:0] cnt_r;
    logic [IDX_W-1:0]          bit_idx_r;
    logic [DATA_WIDTH-1:0]     data_r;
    logic                      par_en_r;
    logic                      par_typ_r;
    logic [PRESCALE_WIDTH-1:0] prescale_r;

    logic                      bit_end_s;
    logic [IDX_W-1:0]          next_idx_s;

    // Bit-period boundary and index of the next data bit to drive.
    always_comb begin
        bit_end_s  = (cnt_r == (prescale_r - PRESCALE_WIDTH'(1)));
        next_idx_s = bit_idx_r + IDX_W'(1);
    end

    // Frame sequencer; tx_out and busy are set one edge ahead so they stay registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            cnt_r      <= '0;
            bit_idx_r  <= '0;
            data_r     <= '0;
            par_en_r   <= 1'b0;
            par_typ_r  <= 1'b0;
            prescale_r <= '0;
            tx_out     <= 1'b1;
            busy       <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    cnt_r     <= '0;
                    bit_idx_r <= '0;
                    if (data_valid) begin
                        data_r     <= p_data;
                        par_en_r   <= par_en;
                        par_typ_r  <= par_typ;
                        prescale_r <= prescale;
                        state_r    <= ST_START;
                        tx_out     <= 1'b0;
                        busy       <= 1'b1;
                    end else begin
                        tx_out <= 1'b1;
                        busy   <= 1'b0;
                    end
                end

                ST_START: begin
                    if (bit_end_s) begin
                        cnt_r     <= '0;
                        bit_idx_r <= '0;
                        state_r   <= ST_DATA;
                        tx_out    <= data_r[0];
                    end else begin
                        cnt_r <= cnt_r + PRESCALE_WIDTH'(1);
                    end
                end

                ST_DATA: begin
                    if (bit_end_s) begin
                        cnt_r <= '0;
                        if (bit_idx_r == LAST_IDX) begin
                            bit_idx_r <= '0;
                            if (par_en_r) begin
                                state_r <= ST_PARITY;
                                tx_out  <= parity_bit(data_r, par_typ_r);
                            end else begin
                                state_r <= ST_STOP;
                                tx_out  <= 1'b1;
                            end
                        end else begin
                            bit_idx_r <= next_idx_s;
                            tx_out    <= data_r[next_idx_s];
                        end
                    end else begin
                        cnt_r <= cnt_r + PRESCALE_WIDTH'(1);
                    end
                end

                ST_PARITY: begin
                    if (bit_end_s) begin
                        cnt_r   <= '0;
                        state_r <= ST_STOP;
                        tx_out  <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + PRESCALE_WIDTH'(1);
                    end
                end

                ST_STOP: begin
                    if (bit_end_s) begin
                        cnt_r   <= '0;
                        state_r <= ST_IDLE;
                        tx_out  <= 1'b1;
                        busy    <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r + PRESCALE_WIDTH'(1);
                    end
                end

                default: begin
                    state_r   <= ST_IDLE;
                    cnt_r     <= '0;
                    bit_idx_r <= '0;
                    tx_out    <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Self-checking bench for uart_tx_frame: a queue-based line model is checked every cycle,
// plus table-driven frames and hand-written back-to-back and mid-frame reset sequences.
module tb_uart_tx_frame;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] p_data;
    logic       data_valid;
    logic       par_en;
    logic       par_typ;
    logic [5:0] prescale;
    logic       tx_out;
    logic       busy;

    int checks = 0;
    int errors = 0;

    // Expected line value for the current and every future cycle of the frame in flight.
    logic mq[$];
    // Line samples captured while busy.
    logic cap[$];

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       pt;
        logic [5:0] ps;
        int         exp_busy;
        logic       exp_par;
    } vec_t;

    vec_t vecs[7];

    uart_tx_frame #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .p_data     (p_data),
        .data_valid (data_valid),
        .par_en     (par_en),
        .par_typ    (par_typ),
        .prescale   (prescale),
        .tx_out     (tx_out),
        .busy       (busy)
    );

    // 10 ns clock.
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Builds the expected waveform from the frame rules: each bit repeated ps times.
    task automatic model_frame(input logic [7:0] d, input logic pe, input logic pt, input logic [5:0] ps);
        logic bits[$];
        int   ones;
        ones = $countones(d);
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(d[i]);
        if (pe) bits.push_back(((ones % 2) == 1) != pt);
        bits.push_back(1'b1);
        foreach (bits[k]) begin
            for (int r = 0; r < int'(ps); r++) mq.push_back(bits[k]);
        end
    endtask

    // One clock: model advances on the edge, DUT is compared at the following negedge.
    task automatic step();
        @(posedge clk);
        if (rst) mq.delete();
        else if (mq.size() != 0) mq.delete(0);
        else if (data_valid) model_frame(p_data, par_en, par_typ, prescale);
        @(negedge clk);
        check("model_tx_out", {31'd0, tx_out}, {31'd0, (mq.size() != 0) ? mq[0] : 1'b1});
        check("model_busy", {31'd0, busy}, {31'd0, mq.size() != 0});
    endtask

    // Appends line samples to cap while busy is high, bounded.
    task automatic measure();
        int n;
        n = 0;
        while (busy === 1'b1 && n < 2000) begin
            cap.push_back(tx_out);
            n++;
            step();
        end
        check("frame_bounded", {31'd0, busy === 1'b1}, 32'd0);
    endtask

    function automatic logic sample(input int idx);
        return (cap.size() > idx) ? cap[idx] : 1'bx;
    endfunction

    task automatic run_vec(input vec_t v);
        int   nb;
        logic e;
        p_data     = v.d;
        par_en     = v.pe;
        par_typ    = v.pt;
        prescale   = v.ps;
        data_valid = 1'b1;
        step();
        data_valid = 1'b0;
        check("accept_busy", {31'd0, busy}, 32'd1);
        // Inputs changing after acceptance must not disturb the frame in flight.
        p_data   = ~v.d;
        par_en   = ~v.pe;
        par_typ  = ~v.pt;
        prescale = (v.ps == 6'd4) ? 6'd9 : 6'd4;
        cap.delete();
        measure();
        check("vec_busy_len", cap.size(), v.exp_busy);
        nb = v.pe ? 11 : 10;
        for (int k = 0; k < nb; k++) begin
            if (k == 0) e = 1'b0;
            else if (k <= 8) e = v.d[k-1];
            else if (k == 9 && v.pe) e = v.exp_par;
            else e = 1'b1;
            check("vec_bit", {31'd0, sample(k * int'(v.ps) + int'(v.ps) / 2)}, {31'd0, e});
        end
        check("vec_idle_tx", {31'd0, tx_out}, 32'd1);
    endtask

    initial begin
        logic [7:0] exp2;

        vecs[0] = '{d: 8'hA5, pe: 1'b1, pt: 1'b0, ps: 6'd8,  exp_busy: 88,  exp_par: 1'b0};
        vecs[1] = '{d: 8'h01, pe: 1'b1, pt: 1'b1, ps: 6'd16, exp_busy: 176, exp_par: 1'b0};
        vecs[2] = '{d: 8'h01, pe: 1'b1, pt: 1'b0, ps: 6'd16, exp_busy: 176, exp_par: 1'b1};
        vecs[3] = '{d: 8'hFF, pe: 1'b0, pt: 1'b0, ps: 6'd8,  exp_busy: 80,  exp_par: 1'b0};
        vecs[4] = '{d: 8'h3C, pe: 1'b1, pt: 1'b1, ps: 6'd4,  exp_busy: 44,  exp_par: 1'b1};
        vecs[5] = '{d: 8'h00, pe: 1'b1, pt: 1'b1, ps: 6'd5,  exp_busy: 55,  exp_par: 1'b1};
        vecs[6] = '{d: 8'hB7, pe: 1'b1, pt: 1'b0, ps: 6'd63, exp_busy: 693, exp_par: 1'b0};

        rst        = 1'b1;
        data_valid = 1'b0;
        p_data     = 8'h00;
        par_en     = 1'b0;
        par_typ    = 1'b0;
        prescale   = 6'd8;
        step();
        step();
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            check("idle_tx", {31'd0, tx_out}, 32'd1);
            check("idle_busy", {31'd0, busy}, 32'd0);
        end

        foreach (vecs[i]) run_vec(vecs[i]);

        // Held data_valid: two 40-cycle frames with exactly one idle cycle between them.
        p_data     = 8'h3C;
        par_en     = 1'b0;
        par_typ    = 1'b0;
        prescale   = 6'd4;
        data_valid = 1'b1;
        step();
        p_data = 8'hC3;
        cap.delete();
        measure();
        check("b2b_len1", cap.size(), 40);
        check("b2b_gap_busy", {31'd0, busy}, 32'd0);
        check("b2b_gap_tx", {31'd0, tx_out}, 32'd1);
        step();
        check("b2b_second_start", {31'd0, busy}, 32'd1);
        data_valid = 1'b0;
        cap.delete();
        for (int i = 0; i < 10; i++) begin
            cap.push_back(tx_out);
            step();
        end
        p_data     = 8'h5A;
        data_valid = 1'b1;
        cap.push_back(tx_out);
        step();
        data_valid = 1'b0;
        measure();
        check("b2b_len2", cap.size(), 40);
        exp2 = 8'hC3;
        for (int k = 1; k <= 8; k++)
            check("b2b_data2", {31'd0, sample(k * 4 + 2)}, {31'd0, exp2[k-1]});

        // Reset in the middle of data bit 3, then a clean frame.
        p_data     = 8'hA5;
        par_en     = 1'b1;
        par_typ    = 1'b0;
        prescale   = 6'd8;
        data_valid = 1'b1;
        step();
        data_valid = 1'b0;
        for (int i = 0; i < 35; i++) step();
        check("pre_rst_bit3", {31'd0, tx_out}, 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_tx", {31'd0, tx_out}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        step();
        check("post_rst_idle", {31'd0, busy}, 32'd0);
        run_vec(vecs[0]);

        // Random traffic, occasional resets, checked against the line model.
        for (int i = 0; i < 4000; i++) begin
            data_valid = ($urandom_range(0, 7) == 0);
            p_data     = 8'($urandom);
            par_en     = 1'($urandom);
            par_typ    = 1'($urandom);
            prescale   = 6'($urandom_range(4, 9));
            rst        = ($urandom_range(0, 299) == 0);
            step();
        end
        rst        = 1'b0;
        data_valid = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
